// File: rtl/div_16x8_seq_if.sv
// div_16x8_seq_if: operand/result valid-ready bundle for div_16x8_seq
interface div_16x8_seq_if #(
  parameter int DW_N = 16,
  parameter int DW_D = 8
);
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic dz;
  logic [DW_N-1:0] A;
  logic [DW_N-1:0] Q;
  logic [DW_D-1:0] B;
  logic [DW_D-1:0] R;
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Q, R, dz);
  modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, Q, R, dz);
endinterface

// File: rtl/div_16x8_seq.sv
// div_16x8_seq: sequential restoring divider, one quotient bit per clock; APPROX_DIV_EN skips the low APPROX_LSB quotient bits
module div_16x8_seq #(
  parameter int DW_N = 16,
  parameter int DW_D = 8,
  parameter int APPROX_LSB = 4
) (
  input logic clk,
  input logic rst_n,
  div_16x8_seq_if.slave bus
);
`ifdef APPROX_DIV_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif
  localparam int SKIP = APPROX ? APPROX_LSB : 0;
  localparam int STEPS = DW_N - SKIP;
  localparam int CW = $clog2(DW_N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [DW_D-1:0] prem;
  logic [DW_D-1:0] prem_nx;
  logic [DW_D-1:0] dsr;
  logic [DW_N-1:0] dvd;
  logic [DW_N-1:0] dvd_nx;
  logic [DW_D:0] trial;
  logic ge;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  // one restoring step: pull in the next dividend bit, subtract the divisor when it fits
  always_comb begin
    trial = {prem, dvd[DW_N-1]};
    ge = trial >= {1'b0, dsr};
    prem_nx = ge ? DW_D'(trial - {1'b0, dsr}) : trial[DW_D-1:0];
    dvd_nx = {dvd[DW_N-2:0], ge};
  end
  // handshake FSM; dvd shifts dividend bits out the top while quotient bits enter at the bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      prem <= '0;
      dsr <= '0;
      dvd <= '0;
      bus.Q <= '0;
      bus.R <= '0;
      bus.dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          dsr <= bus.B;
          dvd <= bus.A;
          cnt <= '0;
          prem <= '0;
          if (bus.B == '0) begin
            state <= DONE;
            bus.Q <= '1;
            bus.R <= bus.A[DW_D-1:0];
            bus.dz <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          prem <= prem_nx;
          dvd <= dvd_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1)) begin
            state <= DONE;
            bus.Q <= dvd_nx << SKIP;
            bus.R <= prem_nx;
            bus.dz <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_16x8_seq.sv
// tb_div_16x8_seq: directed and randomized checks of div_16x8_seq against an arithmetic model
module tb_div_16x8_seq;
  localparam int LSB = 4;
`ifdef APPROX_DIV_EN
  localparam bit APX = 1'b1;
`else
  localparam bit APX = 1'b0;
`endif
  localparam int LAT = APX ? 17 - LSB : 17;
  typedef struct {
    logic [15:0] q;
    logic [7:0] r;
    logic z;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int edges = 0;
  int rdy_mode = 1;
  logic prev_v = 1'b0;
  exp_t exq[$];
  div_16x8_seq_if ifc ();
  div_16x8_seq dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  always #5 clk = ~clk;
  always @(posedge clk) edges++;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int now);
    exp_t e;
    int aa;
    aa = APX ? int'(a) >> LSB : int'(a);
    if (b == 8'd0) begin
      e.q = 16'hFFFF;
      e.r = a[7:0];
      e.z = 1'b1;
      e.due = now + 1;
    end else begin
      e.q = 16'((aa / int'(b)) << (APX ? LSB : 0));
      e.r = 8'(aa % int'(b));
      e.z = 1'b0;
      e.due = now + LAT;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      exq.delete();
      prev_v = 1'b0;
    end else begin
      chk("ready_valid_exclusive", 32'(ifc.in_ready & ifc.out_valid), 32'd0);
      if (ifc.out_valid) begin
        if (exq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: out_valid=1 with no operation pending (t=%0t)", $time);
        end else begin
          if (!prev_v) chk("latency_edge", 32'(edges), 32'(exq[0].due));
          chk("Q", 32'(ifc.Q), 32'(exq[0].q));
          chk("R", 32'(ifc.R), 32'(exq[0].r));
          chk("dz", 32'(ifc.dz), 32'(exq[0].z));
          if (ifc.out_ready) void'(exq.pop_front());
        end
      end
      prev_v = ifc.out_valid;
      if (ifc.in_valid && ifc.in_ready) exq.push_back(model(ifc.A, ifc.B, edges));
    end
  end
  initial begin
    ifc.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ifc.out_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
    end
  end
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int g = 0;
    ifc.A = a;
    ifc.B = b;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ifc.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles");
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.A = 16'($urandom);
    ifc.B = 8'($urandom);
  endtask
  task automatic wait_valid();
    int g = 0;
    @(negedge clk);
    while (!ifc.out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!ifc.out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid stayed 0 for 100 cycles");
    end
  endtask
  task automatic get(output logic [15:0] q, output logic [7:0] r, output logic z);
    int g = 0;
    wait_valid();
    q = ifc.Q;
    r = ifc.R;
    z = ifc.dz;
    while (ifc.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (ifc.out_valid) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: out_valid stayed 1 for 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] q;
    logic [7:0] r;
    logic z;
    logic [15:0] ta [4] = '{16'h0000, 16'hABCD, 16'hFFFF, 16'h00FE};
    logic [7:0] tb [4] = '{8'h03, 8'h01, 8'h02, 8'hFF};
    ifc.in_valid = 1'b0;
    ifc.A = '0;
    ifc.B = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("reset_Q", 32'(ifc.Q), 32'd0);
    chk("reset_R", 32'(ifc.R), 32'd0);
    chk("reset_dz", 32'(ifc.dz), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd1000, 8'd7);
    get(q, r, z);
    chk("basic_Q", 32'(q), APX ? 32'd128 : 32'd142);
    chk("basic_R", 32'(r), 32'd6);
    chk("basic_dz", 32'(z), 32'd0);
    send(16'hFFFF, 8'hFF);
    get(q, r, z);
    chk("full_Q", 32'(q), APX ? 32'h0100 : 32'h0101);
    chk("full_R", 32'(r), APX ? 32'd15 : 32'd0);
    send(16'd5, 8'd10);
    get(q, r, z);
    chk("small_Q", 32'(q), 32'd0);
    chk("small_R", 32'(r), APX ? 32'd0 : 32'd5);
    send(16'h1234, 8'd0);
    get(q, r, z);
    chk("dz_Q", 32'(q), 32'hFFFF);
    chk("dz_R", 32'(r), 32'h34);
    chk("dz_flag", 32'(z), 32'd1);
    rdy_mode = 0;
    send(16'd200, 8'd3);
    wait_valid();
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b1;
    ifc.A = 16'd777;
    ifc.B = 8'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("bp_Q", 32'(ifc.Q), APX ? 32'd64 : 32'd66);
      chk("bp_R", 32'(ifc.R), APX ? 32'd0 : 32'd2);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    send(16'd777, 8'd5);
    get(q, r, z);
    chk("bp_second_Q", 32'(q), APX ? 32'd144 : 32'd155);
    chk("bp_second_R", 32'(r), APX ? 32'd3 : 32'd2);
    send(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midreset_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("midreset_Q", 32'(ifc.Q), 32'd0);
    chk("midreset_R", 32'(ifc.R), 32'd0);
    chk("midreset_dz", 32'(ifc.dz), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd1000, 8'd7);
    get(q, r, z);
    chk("after_reset_Q", 32'(q), APX ? 32'd128 : 32'd142);
    chk("after_reset_R", 32'(r), 32'd6);
    rdy_mode = 2;
    for (int i = 0; i < 44; i++) begin
      logic [15:0] a;
      logic [7:0] b;
      a = i < 4 ? ta[i] : 16'($urandom);
      b = i < 4 ? tb[i] : ($urandom_range(0, 5) == 0 ? 8'd0 : 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(a, b);
      get(q, r, z);
    end
    chk("queue_drained", 32'(exq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
